// File: rtl/dma_ch_arbiter.sv
// Grants one DMA channel at a time to the shared AHB master: top priority wins, round-robin within a level.
// One cycle from request to grant; the owner keeps the bus until done, disable or hold watchdog, then one idle cycle.
module dma_ch_arbiter #(
    parameter int CHANNEL_NUM = 8,
    parameter int MAX_HOLD    = 256
) (
    input  logic                                 clk,
    input  logic                                 areset,
    input  logic                                 arb_en_i,
    input  logic [CHANNEL_NUM-1:0]               ch_enable_i,
    input  logic [CHANNEL_NUM-1:0][1:0]          ch_prior_i,
    input  logic [CHANNEL_NUM-1:0]               ch_req_i,
    input  logic [CHANNEL_NUM-1:0]               ch_done_i,
    output logic [CHANNEL_NUM-1:0]               gnt_o,
    output logic                                 gnt_valid_o,
    output logic [$clog2(CHANNEL_NUM)-1:0]       gnt_idx_o,
    output logic                                 timeout_o,
    output logic [$clog2(CHANNEL_NUM)-1:0]       timeout_idx_o
);

    localparam int IDX_W     = $clog2(CHANNEL_NUM);
    localparam int HOLD_W    = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam int HOLD_LAST = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                   state_q, state_d;
    logic [CHANNEL_NUM-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]         gnt_idx_q, gnt_idx_d;
    logic [HOLD_W-1:0]        hold_q, hold_d;
    logic                     timeout_q, timeout_d;
    logic [IDX_W-1:0]         timeout_idx_q, timeout_idx_d;
    logic [IDX_W-1:0]         rr_ptr_q [4];
    logic [IDX_W-1:0]         rr_ptr_d [4];

    logic [CHANNEL_NUM-1:0]   elig;
    logic [1:0]               top;
    logic [IDX_W:0]           scan;
    logic [IDX_W-1:0]         win;
    logic [IDX_W-1:0]         win_next;
    logic                     found;
    logic                     rel_ab;
    logic                     rel_wd;

    // Winner search: highest eligible priority, then first match at or after that level's pointer.
    always_comb begin
        elig  = ch_req_i & ch_enable_i;
        top   = 2'd0;
        scan  = '0;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < CHANNEL_NUM; i++) begin
            if (elig[i] && (ch_prior_i[i] > top)) begin
                top = ch_prior_i[i];
            end
        end
        for (int j = 0; j < CHANNEL_NUM; j++) begin
            scan = {1'b0, rr_ptr_q[top]} + (IDX_W+1)'(j);
            if (scan >= (IDX_W+1)'(CHANNEL_NUM)) begin
                scan = scan - (IDX_W+1)'(CHANNEL_NUM);
            end
            if (!found && elig[scan[IDX_W-1:0]] && (ch_prior_i[scan[IDX_W-1:0]] == top)) begin
                found = 1'b1;
                win   = scan[IDX_W-1:0];
            end
        end
        win_next = (win == IDX_W'(CHANNEL_NUM - 1)) ? '0 : win + IDX_W'(1);
    end

    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        gnt_idx_d     = gnt_idx_q;
        hold_d        = hold_q;
        timeout_d     = 1'b0;
        timeout_idx_d = timeout_idx_q;
        rr_ptr_d      = rr_ptr_q;
        rel_ab        = ch_done_i[gnt_idx_q] | ~ch_enable_i[gnt_idx_q];
        rel_wd        = (MAX_HOLD != 0) && (hold_q == HOLD_W'(HOLD_LAST));
        case (state_q)
            IDLE: begin
                if (arb_en_i && found) begin
                    state_d       = GRANT;
                    gnt_d         = '0;
                    gnt_d[win]    = 1'b1;
                    gnt_idx_d     = win;
                    hold_d        = '0;
                    rr_ptr_d[top] = win_next;
                end
            end
            GRANT: begin
                if (rel_ab || rel_wd) begin
                    state_d   = IDLE;
                    gnt_d     = '0;
                    gnt_idx_d = '0;
                    // A watchdog expiry coinciding with done/disable is an ordinary release.
                    if (!rel_ab) begin
                        timeout_d     = 1'b1;
                        timeout_idx_d = gnt_idx_q;
                    end
                end else if (hold_q != HOLD_W'(HOLD_LAST)) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q       <= IDLE;
            gnt_q         <= '0;
            gnt_idx_q     <= '0;
            hold_q        <= '0;
            timeout_q     <= 1'b0;
            timeout_idx_q <= '0;
            for (int p = 0; p < 4; p++) begin
                rr_ptr_q[p] <= '0;
            end
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            gnt_idx_q     <= gnt_idx_d;
            hold_q        <= hold_d;
            timeout_q     <= timeout_d;
            timeout_idx_q <= timeout_idx_d;
            rr_ptr_q      <= rr_ptr_d;
        end
    end

    assign gnt_o         = gnt_q;
    assign gnt_valid_o   = |gnt_q;
    assign gnt_idx_o     = gnt_idx_q;
    assign timeout_o     = timeout_q;
    assign timeout_idx_o = timeout_idx_q;

endmodule

// File: tb/tb_dma_ch_arbiter.sv
// Directed bench for dma_ch_arbiter with an 8-channel instance and a 4-cycle hold watchdog.
module tb_dma_ch_arbiter;

    logic             clk;
    logic             areset;
    logic             arb_en;
    logic [7:0]       en;
    logic [7:0][1:0]  prior;
    logic [7:0]       req;
    logic [7:0]       done;
    logic [7:0]       gnt;
    logic             valid;
    logic [2:0]       idx;
    logic             tout;
    logic [2:0]       tidx;

    int checks = 0;
    int errors = 0;

    dma_ch_arbiter #(.CHANNEL_NUM(8), .MAX_HOLD(4)) dut (
        .clk           (clk),
        .areset        (areset),
        .arb_en_i      (arb_en),
        .ch_enable_i   (en),
        .ch_prior_i    (prior),
        .ch_req_i      (req),
        .ch_done_i     (done),
        .gnt_o         (gnt),
        .gnt_valid_o   (valid),
        .gnt_idx_o     (idx),
        .timeout_o     (tout),
        .timeout_idx_o (tidx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full service: grant appears, done pulse, bus returns to idle.
    task automatic serve(input string tag, input logic [7:0] exp_gnt, input logic [2:0] exp_idx);
        tick();
        chk({tag, "_gnt"}, gnt, exp_gnt);
        chk({tag, "_idx"}, idx, exp_idx);
        done = exp_gnt;
        tick();
        done = '0;
        chk({tag, "_rel"}, gnt, 8'h00);
    endtask

    // Structural invariants, sampled away from the active edge.
    logic [7:0] prev_gnt = '0;
    always @(negedge clk) begin
        if (!areset) begin
            checks++;
            assert ($onehot0(gnt)) else begin
                errors++;
                $error("FAIL inv_onehot: observed %0h expected onehot0", gnt);
            end
            checks++;
            assert (valid === (|gnt)) else begin
                errors++;
                $error("FAIL inv_valid: observed %0b expected %0b", valid, |gnt);
            end
            checks++;
            assert (gnt[idx] === valid) else begin
                errors++;
                $error("FAIL inv_idx: observed %0b expected %0b", gnt[idx], valid);
            end
            if (prev_gnt != 8'h00 && gnt != 8'h00) begin
                checks++;
                assert (gnt === prev_gnt) else begin
                    errors++;
                    $error("FAIL inv_switch: observed %0h expected %0h", gnt, prev_gnt);
                end
            end
            prev_gnt = gnt;
        end else begin
            prev_gnt = '0;
        end
    end

    initial begin
        areset = 1'b1;
        arb_en = 1'b0;
        en     = '0;
        prior  = '0;
        req    = '0;
        done   = '0;
        #2;
        chk("rst_gnt",   gnt,   8'h00);
        chk("rst_valid", valid, 1'b0);
        chk("rst_idx",   idx,   3'd0);
        chk("rst_tout",  tout,  1'b0);
        chk("rst_tidx",  tidx,  3'd0);
        tick();
        areset = 1'b0;
        arb_en = 1'b1;

        // Single requester on ch2.
        req = 8'h04;
        en  = 8'h04;
        chk("single_pre", gnt, 8'h00);
        tick();
        chk("single_gnt",   gnt,   8'h04);
        chk("single_idx",   idx,   3'd2);
        chk("single_valid", valid, 1'b1);
        done = 8'h04;
        req  = 8'h00;
        tick();
        done = '0;
        chk("single_rel",   gnt,   8'h00);
        chk("single_rel_v", valid, 1'b0);

        // Priority: ch5/ch6 at 3 alternate, ch1 at 1 starves until they drop.
        prior[1] = 2'd1;
        prior[5] = 2'd3;
        prior[6] = 2'd3;
        req = 8'h62;
        en  = 8'h62;
        serve("prio_a", 8'h20, 3'd5);
        serve("prio_b", 8'h40, 3'd6);
        serve("prio_c", 8'h20, 3'd5);
        serve("prio_d", 8'h40, 3'd6);
        req = 8'h02;
        serve("prio_low", 8'h02, 3'd1);
        req = '0;

        // Round-robin wrap at priority 2.
        prior    = '0;
        prior[0] = 2'd2;
        prior[3] = 2'd2;
        prior[7] = 2'd2;
        req = 8'h89;
        en  = 8'h89;
        serve("rr_0", 8'h01, 3'd0);
        serve("rr_3", 8'h08, 3'd3);
        serve("rr_7", 8'h80, 3'd7);
        serve("rr_w", 8'h01, 3'd0);
        req = '0;

        // Watchdog: ch3 held four GRANT cycles, then revoked.
        prior = '0;
        req = 8'h08;
        en  = 8'h08;
        tick();
        chk("wd_g1", gnt, 8'h08);
        chk("wd_t1", tout, 1'b0);
        tick();
        chk("wd_g2", gnt, 8'h08);
        tick();
        chk("wd_g3", gnt, 8'h08);
        tick();
        chk("wd_g4", gnt, 8'h08);
        chk("wd_t4", tout, 1'b0);
        tick();
        chk("wd_rel",  gnt,  8'h00);
        chk("wd_tout", tout, 1'b1);
        chk("wd_tidx", tidx, 3'd3);
        tick();
        chk("wd_pulse", tout, 1'b0);
        chk("wd_regnt", gnt,  8'h08);
        tick();
        tick();
        tick();
        chk("wd_done_g4", gnt, 8'h08);
        done = 8'h08;
        tick();
        done = '0;
        req  = '0;
        chk("wd_done_rel",  gnt,  8'h00);
        chk("wd_done_tout", tout, 1'b0);
        chk("wd_tidx_hold", tidx, 3'd3);

        // Abort by disable; done on a non-owner is ignored.
        req = 8'h10;
        en  = 8'h10;
        tick();
        chk("ab_gnt", gnt, 8'h10);
        done = 8'h04;
        tick();
        done = '0;
        chk("ab_foreign_done", gnt, 8'h10);
        en = 8'h00;
        tick();
        chk("ab_rel",  gnt,  8'h00);
        chk("ab_tout", tout, 1'b0);

        // arb_en low blocks new grants.
        arb_en = 1'b0;
        en     = 8'h10;
        tick();
        chk("dis_1", gnt, 8'h00);
        tick();
        chk("dis_2", gnt, 8'h00);
        arb_en = 1'b1;
        tick();
        chk("dis_gnt", gnt, 8'h10);

        // Asynchronous reset mid-grant.
        #2;
        areset = 1'b1;
        #1;
        chk("arst_gnt",   gnt,   8'h00);
        chk("arst_valid", valid, 1'b0);
        chk("arst_idx",   idx,   3'd0);
        chk("arst_tidx",  tidx,  3'd0);
        areset = 1'b0;
        req = 8'h03;
        en  = 8'h03;
        serve("arst_rr", 8'h01, 3'd0);
        req = '0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
